// File: rtl/io_ring_pwr_seq_if.sv
// -----------------------------------------------------------------------------
// io_ring_pwr_seq_if
// Bundles the supply-good indicators, the shutdown request and the pad-control
// outputs of the IO-ring power sequencer.
//
// Signals
//   DVDD_OK    supply monitor -> sequencer   IO supply good (asynchronous)
//   VDD_OK     supply monitor -> sequencer   core supply good (asynchronous)
//   FORCE_OFF  controller     -> sequencer   ordered shutdown / hold-off request
//   ISO_N      sequencer -> pads             isolation release (0 = isolated)
//   IE         sequencer -> pads             input buffer enable
//   OE_EN      sequencer -> pads             output enable gate
//   READY      sequencer -> controller       ring fully enabled
//   STATE      sequencer -> controller       current sequencer state
//   FAULT_CNT  sequencer -> controller       saturating supply-loss abort count
//
// Modports
//   master  supply monitor / controller side (drives the requests)
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface io_ring_pwr_seq_if;
  logic       DVDD_OK;
  logic       VDD_OK;
  logic       FORCE_OFF;
  logic       ISO_N;
  logic       IE;
  logic       OE_EN;
  logic       READY;
  logic [2:0] STATE;
  logic [7:0] FAULT_CNT;

  modport master (
    output DVDD_OK,
    output VDD_OK,
    output FORCE_OFF,
    input  ISO_N,
    input  IE,
    input  OE_EN,
    input  READY,
    input  STATE,
    input  FAULT_CNT
  );

  modport slave (
    input  DVDD_OK,
    input  VDD_OK,
    input  FORCE_OFF,
    output ISO_N,
    output IE,
    output OE_EN,
    output READY,
    output STATE,
    output FAULT_CNT
  );
endinterface : io_ring_pwr_seq_if

// File: rtl/io_ring_pwr_seq.sv
// -----------------------------------------------------------------------------
// io_ring_pwr_seq
// Power-good sequencer for the gf180mcu IO ring. Synchronises and debounces
// the DVDD/VDD good indicators, then releases pad isolation, input buffers and
// output enables in a fixed timed order. Any supply loss while the pads are
// (partly) enabled drops everything to the safe state on the next edge and is
// counted; FORCE_OFF walks the ring back down in reverse order.
//
// Ports
//   CLK   input   sequencer clock, rising edge
//   RN    input   asynchronous active-low reset (clears all state and outputs)
//   bus   slave   supply indicators, shutdown request and pad controls
//
// State encoding (STATE output)
//   0 OFF  1 DEB  2 ISO_REL  3 IE_ON  4 RUN  5 OE_OFF  6 IE_OFF  (7 unused)
// -----------------------------------------------------------------------------
module io_ring_pwr_seq #(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned STEP_CYCLES = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RN,
  io_ring_pwr_seq_if.slave bus
);

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_DEB     = 3'd1;
  localparam logic [2:0] ST_ISO_REL = 3'd2;
  localparam logic [2:0] ST_IE_ON   = 3'd3;
  localparam logic [2:0] ST_RUN     = 3'd4;
  localparam logic [2:0] ST_OE_OFF  = 3'd5;
  localparam logic [2:0] ST_IE_OFF  = 3'd6;

  // One shared dwell counter; it only ever has to reach the larger dwell - 1.
  localparam int unsigned MAX_CYC = (DEB_CYCLES > STEP_CYCLES) ? DEB_CYCLES : STEP_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Pad enable pattern {ISO_N, IE, OE_EN, READY} for a given state. Unused
  // encodings map to the fully isolated pattern.
  function automatic logic [3:0] pad_enables(input logic [2:0] st);
    logic [3:0] en;
    case (st)
      ST_ISO_REL: en = 4'b1000;
      ST_IE_ON:   en = 4'b1100;
      ST_RUN:     en = 4'b1111;
      ST_OE_OFF:  en = 4'b1100;
      ST_IE_OFF:  en = 4'b1000;
      default:    en = 4'b0000;
    endcase
    return en;
  endfunction

  logic [SYNC_STAGES-1:0] dvdd_sync_q;
  logic [SYNC_STAGES-1:0] vdd_sync_q;
  logic                   good_s;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       fault_q, fault_d;
  logic             iso_n_q, ie_q, oe_en_q, ready_q;

  logic             deb_done_s;
  logic             step_done_s;
  logic             timed_s;
  logic             pads_live_s;
  logic             abort_s;

  // Synchronise both supply-good inputs into the CLK domain.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      dvdd_sync_q <= {SYNC_STAGES{1'b0}};
      vdd_sync_q  <= {SYNC_STAGES{1'b0}};
    end else begin
      dvdd_sync_q <= {dvdd_sync_q[SYNC_STAGES-2:0], bus.DVDD_OK};
      vdd_sync_q  <= {vdd_sync_q[SYNC_STAGES-2:0], bus.VDD_OK};
    end
  end

  assign good_s      = dvdd_sync_q[SYNC_STAGES-1] & vdd_sync_q[SYNC_STAGES-1];
  assign deb_done_s  = (cnt_q == DEB_LAST);
  assign step_done_s = (cnt_q == STEP_LAST);

  // States that hold some pad function enabled; losing a supply here is a fault.
  assign pads_live_s = (state_q >= ST_ISO_REL) && (state_q <= ST_IE_OFF);
  assign abort_s     = pads_live_s && !good_s;

  // States that measure a dwell with the shared counter.
  assign timed_s = (state_q == ST_DEB)   || (state_q == ST_ISO_REL) ||
                   (state_q == ST_IE_ON) || (state_q == ST_OE_OFF)  ||
                   (state_q == ST_IE_OFF);

  // Next-state logic; supply loss takes priority over FORCE_OFF and any dwell.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (good_s && !bus.FORCE_OFF) begin
          state_d = ST_DEB;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_DEB: begin
        if (!good_s || bus.FORCE_OFF) begin
          state_d = ST_OFF;
        end else if (deb_done_s) begin
          state_d = ST_ISO_REL;
        end else begin
          state_d = ST_DEB;
        end
      end
      ST_ISO_REL: begin
        // IE was never enabled, so a shutdown skips straight to IE_OFF.
        if (!good_s) begin
          state_d = ST_OFF;
        end else if (bus.FORCE_OFF) begin
          state_d = ST_IE_OFF;
        end else if (step_done_s) begin
          state_d = ST_IE_ON;
        end else begin
          state_d = ST_ISO_REL;
        end
      end
      ST_IE_ON: begin
        // OE_EN was never enabled, so a shutdown starts at OE_OFF.
        if (!good_s) begin
          state_d = ST_OFF;
        end else if (bus.FORCE_OFF) begin
          state_d = ST_OE_OFF;
        end else if (step_done_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IE_ON;
        end
      end
      ST_RUN: begin
        if (!good_s) begin
          state_d = ST_OFF;
        end else if (bus.FORCE_OFF) begin
          state_d = ST_OE_OFF;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_OE_OFF: begin
        // Shutdown always runs to completion; FORCE_OFF is not looked at.
        if (!good_s) begin
          state_d = ST_OFF;
        end else if (step_done_s) begin
          state_d = ST_IE_OFF;
        end else begin
          state_d = ST_OE_OFF;
        end
      end
      ST_IE_OFF: begin
        if (!good_s) begin
          state_d = ST_OFF;
        end else if (step_done_s) begin
          state_d = ST_OFF;
        end else begin
          state_d = ST_IE_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Dwell counter: restarts on every state change, idles at zero elsewhere.
  always_comb begin
    cnt_d = CNT_ZERO;
    if (state_d != state_q) begin
      cnt_d = CNT_ZERO;
    end else if (timed_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // Supply-loss abort counter, saturating at all-ones.
  always_comb begin
    fault_d = fault_q;
    if (abort_s && (fault_q != 8'hFF)) begin
      fault_d = fault_q + 8'd1;
    end else begin
      fault_d = fault_q;
    end
  end

  // State, counters and pad outputs; pads are decoded from the next state so
  // they change on the same edge as STATE.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_OFF;
      cnt_q   <= CNT_ZERO;
      fault_q <= 8'd0;
      iso_n_q <= 1'b0;
      ie_q    <= 1'b0;
      oe_en_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      {iso_n_q, ie_q, oe_en_q, ready_q} <= pad_enables(state_d);
    end
  end

  assign bus.ISO_N     = iso_n_q;
  assign bus.IE        = ie_q;
  assign bus.OE_EN     = oe_en_q;
  assign bus.READY     = ready_q;
  assign bus.STATE     = state_q;
  assign bus.FAULT_CNT = fault_q;

endmodule : io_ring_pwr_seq

// File: doc/io_ring_pwr_seq.md
Name: io_ring_pwr_seq

Overview:
- Power-good sequencer for the gf180mcu IO ring.
- Sits between the supply monitors and the pad cells (signal pads, and filler/corner cells carrying DVDD/DVSS/VDD/VSS).
- Monitors the DVDD and VDD good indicators, debounces them, then releases pad isolation, input buffers and output enables in a fixed timed order.
- Forces pads safe immediately on supply loss; also supports an ordered software shutdown.

Parameters:
- DEB_CYCLES, 16, consecutive synchronised cycles both supplies must be good before sequencing starts (>=1).
- STEP_CYCLES, 8, dwell cycles in each intermediate sequencing state (>=1).
- SYNC_STAGES, 2, synchroniser flop depth on DVDD_OK and VDD_OK (>=2).

Ports:
- CLK  input  1  sequencer clock, rising edge.
- RN  input  1  asynchronous active-low reset.
- DVDD_OK  input  1  IO supply good; asynchronous, synchronised internally.
- VDD_OK  input  1  core supply good; asynchronous, synchronised internally.
- FORCE_OFF  input  1  synchronous request for ordered shutdown / hold-off.
- ISO_N  output  1  pad isolation release (0 = isolated).
- IE  output  1  pad input buffer enable.
- OE_EN  output  1  pad output enable gate.
- READY  output  1  ring fully enabled.
- STATE  output  3  current state encoding.
- FAULT_CNT  output  8  saturating count of supply-loss aborts.

Behaviour:
- Clock and reset: one clock, CLK; reset is asynchronous and active-low (RN).
- Reset value of every output: 0, which means STATE=OFF and pads isolated. Synchroniser flops reset to 0.
- Supply good: good_s = AND of the SYNC_STAGES-deep synchronised DVDD_OK and VDD_OK. Input-to-good_s latency is SYNC_STAGES cycles.
- All outputs are registered and reflect the current STATE register. No combinational input-to-output paths.
- A single counter cnt is used, sized for max(DEB_CYCLES, STEP_CYCLES). It clears on every state change.
- States and transitions:
  - OFF(0): all outputs 0. Goes to DEB when good_s=1 and FORCE_OFF=0.
  - DEB(1): all outputs 0; cnt increments. Goes to OFF if good_s=0 or FORCE_OFF=1 (not counted as a fault). Goes to ISO_REL when cnt==DEB_CYCLES-1 (dwell exactly DEB_CYCLES cycles).
  - ISO_REL(2): ISO_N=1. Goes to IE_ON after STEP_CYCLES cycles.
  - IE_ON(3): ISO_N=1, IE=1. Goes to RUN after STEP_CYCLES cycles.
  - RUN(4): ISO_N=IE=OE_EN=READY=1. Goes to OE_OFF on FORCE_OFF=1.
  - OE_OFF(5): ISO_N=1, IE=1, OE_EN=0, READY=0. Goes to IE_OFF after STEP_CYCLES cycles.
  - IE_OFF(6): ISO_N=1, IE=0. Goes to OFF after STEP_CYCLES cycles.
  - Encoding 7 is unreachable; if ever entered, go to OFF next cycle.
- FORCE_OFF in ISO_REL or IE_ON:
  - ISO_REL goes to IE_OFF, since IE is already 0.
  - IE_ON goes to OE_OFF, since OE_EN is already 0.
  - FORCE_OFF is ignored in OE_OFF and IE_OFF; shutdown always completes.
- Supply loss (good_s=0) in states 2-6:
  - Next state is OFF, with all outputs 0 on the following edge.
  - This overrides FORCE_OFF and any dwell in progress.
  - FAULT_CNT increments by 1 and saturates at 255, with no wrap.
- FORCE_OFF held high keeps the block in OFF. Restart needs FORCE_OFF=0 and a full new debounce.
- Reset asserted mid-sequence: all outputs drop to 0 asynchronously and FAULT_CNT clears.

Test Plan:
- Power-up: reset released, DVDD_OK=VDD_OK=1 → DEB entered 3 edges after first sampling edge, ISO_N=1 16 cycles later, IE=1 8 later, OE_EN=READY=1 8 later. READY at edge 35 with defaults.
- Glitch in debounce: VDD_OK low for 1 cycle while in DEB at cnt=10 → OFF, then full 16-cycle debounce again, FAULT_CNT stays 0.
- Ordered shutdown: FORCE_OFF pulsed 1 cycle in RUN → OE_EN,READY=0 next edge; IE=0 8 cycles later; ISO_N=0, STATE=0 8 cycles after that.
- Supply loss in RUN: DVDD_OK drops → all outputs 0 exactly SYNC_STAGES+1 edges later, FAULT_CNT=1. Repeat 300 times → FAULT_CNT=255.
- Simultaneous: FORCE_OFF=1 and supply loss in the same cycle in IE_ON → OFF directly, FAULT_CNT increments.
- Async reset asserted in OE_OFF → all outputs 0 without a clock edge; after release with supplies good, full sequence restarts from OFF.
